// File: rtl/axi4_param_fetch_sequencer.sv
// Layer parameter fetch sequencer: issues one bias DMA command followed by
// mode-sized weight chunks on a single AXI4 HP read-DMA command port.
module axi4_param_fetch_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 32,
  parameter int CHUNK_3X3 = 4608,
  parameter int CHUNK_1X1 = 2048,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              layer_start,
  input  logic [1:0]        mode,
  input  logic              en_bias,
  input  logic [ADDR_W-1:0] bias_addr,
  input  logic [LEN_W-1:0]  bias_bytes,
  input  logic [ADDR_W-1:0] weight_addr,
  input  logic [LEN_W-1:0]  weight_bytes,
  input  logic              abort,
  input  logic              bias_bram_full,
  input  logic              wbuf_ready,
  input  logic              dma_done,
  output logic              dma_start,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [LEN_W-1:0]  dma_bytes,
  output logic              is_bias,
  output logic              busy,
  output logic              layer_done,
  output logic [CNT_W-1:0]  chunk_cnt
);

  typedef enum logic [2:0] {
    IDLE, B_REQ, B_WAIT, B_FULL, W_REQ, W_WAIT, DONE
  } state_t;

  localparam logic [LEN_W-1:0] CHUNK_3X3_L = LEN_W'(CHUNK_3X3);
  localparam logic [LEN_W-1:0] CHUNK_1X1_L = LEN_W'(CHUNK_1X1);

  state_t            state;
  logic              is_3x3;
  logic [ADDR_W-1:0] work_addr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  chunk_max;
  logic [LEN_W-1:0]  chunk;

  // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    chunk_max = is_3x3 ? CHUNK_3X3_L : CHUNK_1X1_L;
    chunk     = (remaining < chunk_max) ? remaining : chunk_max;
  end

  // NOTE: all state and outputs use non-blocking assignments so every register
  // sees the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_3x3     <= 1'b0;
      work_addr  <= '0;
      remaining  <= '0;
      dma_start  <= 1'b0;
      dma_addr   <= '0;
      dma_bytes  <= '0;
      is_bias    <= 1'b0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
      chunk_cnt  <= '0;
    end else begin
      // Strobes default low; only the REQ->WAIT and W_REQ->DONE edges raise them.
      dma_start  <= 1'b0;
      layer_done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        is_bias <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (layer_start && (mode == 2'b01 || mode == 2'b10)) begin
              is_3x3    <= (mode == 2'b01);
              work_addr <= weight_addr;
              remaining <= weight_bytes;
              chunk_cnt <= '0;
              busy      <= 1'b1;
              if (en_bias && bias_bytes != '0) begin
                state   <= B_REQ;
                is_bias <= 1'b1;
              end else begin
                state <= W_REQ;
              end
            end
          end
          B_REQ: begin
            dma_start <= 1'b1;
            dma_addr  <= bias_addr;
            dma_bytes <= bias_bytes;
            state     <= B_WAIT;
          end
          B_WAIT: begin
            if (dma_done) state <= B_FULL;
          end
          B_FULL: begin
            if (bias_bram_full) begin
              state   <= W_REQ;
              is_bias <= 1'b0;
            end
          end
          W_REQ: begin
            if (remaining == '0) begin
              state      <= DONE;
              layer_done <= 1'b1;
            end else if (wbuf_ready) begin
              dma_start <= 1'b1;
              dma_addr  <= work_addr;
              dma_bytes <= chunk;
              state     <= W_WAIT;
            end
          end
          W_WAIT: begin
            // dma_bytes still holds the size of the chunk just completed.
            if (dma_done) begin
              work_addr <= work_addr + ADDR_W'(dma_bytes);
              remaining <= remaining - dma_bytes;
              if (chunk_cnt != '1) chunk_cnt <= chunk_cnt + CNT_W'(1);
              state <= W_REQ;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi4_param_fetch_sequencer.sv
// Scoreboard bench: a command-list model predicts every DMA command and
// layer_done; a monitor pops and compares whenever the sequencer strobes.
module tb_axi4_param_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        layer_start;
  logic [1:0]  mode;
  logic        en_bias;
  logic [31:0] bias_addr, bias_bytes, weight_addr, weight_bytes;
  logic        abort;
  logic        bias_bram_full;
  logic        wbuf_ready;
  logic        dma_done;
  logic        dma_start;
  logic [31:0] dma_addr, dma_bytes;
  logic        is_bias, busy, layer_done;
  logic [15:0] chunk_cnt;

  logic resp_done = 1'b0, stray_done = 1'b0, resp_en = 1'b1;
  logic wbuf_main = 1'b1, wbuf_rand = 1'b1, rand_wbuf = 1'b0;
  int   resp_delay = 5;

  assign dma_done   = resp_done | stray_done;
  assign wbuf_ready = wbuf_main & (wbuf_rand | ~rand_wbuf);

  always #5 clk = ~clk;

  axi4_param_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .layer_start(layer_start), .mode(mode),
    .en_bias(en_bias), .bias_addr(bias_addr), .bias_bytes(bias_bytes),
    .weight_addr(weight_addr), .weight_bytes(weight_bytes), .abort(abort),
    .bias_bram_full(bias_bram_full), .wbuf_ready(wbuf_ready), .dma_done(dma_done),
    .dma_start(dma_start), .dma_addr(dma_addr), .dma_bytes(dma_bytes),
    .is_bias(is_bias), .busy(busy), .layer_done(layer_done), .chunk_cnt(chunk_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] bytes;
    logic        bias;
  } cmd_t;

  cmd_t exp_q[$];
  int   exp_done   = 0;
  int   exp_chunks = 0;
  int   checks     = 0;
  int   errors     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: list of commands a layer must produce, from plain arithmetic.
  task automatic model_layer(input logic [1:0] m, input logic eb,
                             input logic [31:0] ba, input logic [31:0] bb,
                             input logic [31:0] wa, input logic [31:0] wb);
    logic [31:0] rem, a, csz, c;
    int n;
    if (m != 2'b01 && m != 2'b10) return;
    if (eb && bb != 0) exp_q.push_back('{ba, bb, 1'b1});
    csz = (m == 2'b01) ? 32'd4608 : 32'd2048;
    rem = wb;
    a   = wa;
    n   = 0;
    while (rem > 0) begin
      c = (rem < csz) ? rem : csz;
      exp_q.push_back('{a, c, 1'b0});
      a   = a + c;
      rem = rem - c;
      n++;
    end
    exp_done++;
    exp_chunks = n;
  endtask

  task automatic launch(input logic [1:0] m, input logic eb,
                        input logic [31:0] ba, input logic [31:0] bb,
                        input logic [31:0] wa, input logic [31:0] wb);
    model_layer(m, eb, ba, bb, wa, wb);
    @(posedge clk); #1;
    layer_start = 1'b1; mode = m; en_bias = eb;
    bias_addr = ba; bias_bytes = bb; weight_addr = wa; weight_bytes = wb;
    @(posedge clk); #1;
    layer_start = 1'b0;
    // Weight fields and mode are latched already; scramble them.
    mode = 2'($urandom); weight_addr = $urandom; weight_bytes = $urandom;
  endtask

  task automatic wait_strobe(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (dma_start) found = 1'b1;
    end
    if (!found) check("strobe timeout", 0, 1);
  endtask

  task automatic wait_layer_done(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (layer_done) found = 1'b1;
    end
    if (!found) check("layer_done timeout", 0, 1);
  endtask

  task automatic pulse_stray(input logic with_abort);
    @(posedge clk); #1;
    stray_done = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    stray_done = 1'b0; abort = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dma_start) begin
          if (exp_q.size() == 0) begin
            check("unexpected dma_start", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("dma_addr", dma_addr, e.addr);
            check("dma_bytes", dma_bytes, e.bytes);
            check("is_bias", is_bias, e.bias);
          end
        end
        if (layer_done) begin
          check("layer_done expected", exp_done > 0, 1);
          if (exp_done > 0) exp_done--;
        end
      end
    end
  end

  // DMA responder: completes each command resp_delay cycles after its strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (dma_start && resp_en) begin
        repeat (resp_delay) @(posedge clk);
        #1 resp_done = 1'b1;
        @(posedge clk);
        #1 resp_done = 1'b0;
      end
    end
  end

  // Bias buffer: reports full 3 cycles after the bias transfer completes.
  initial begin
    bias_bram_full = 1'b0;
    forever begin
      @(negedge clk);
      if (dma_done && is_bias) begin
        repeat (3) @(posedge clk);
        #1 bias_bram_full = 1'b1;
        @(posedge clk);
        #1 bias_bram_full = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 wbuf_rand = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int stall_strobes, addr_changes, busy_hits;
    logic [31:0] a0;
    logic [1:0]  m;
    logic        eb;
    logic [31:0] ba, bb, wa, wb;

    rst_n = 1'b0; layer_start = 1'b0; mode = 2'b00; en_bias = 1'b0;
    bias_addr = 0; bias_bytes = 0; weight_addr = 0; weight_bytes = 0; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset dma_start", dma_start, 0);
    check("reset dma_addr", dma_addr, 0);
    check("reset dma_bytes", dma_bytes, 0);
    check("reset is_bias", is_bias, 0);
    check("reset busy", busy, 0);
    check("reset layer_done", layer_done, 0);
    check("reset chunk_cnt", chunk_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 3x3 with bias, plus a layer_start while busy that must be ignored
    resp_delay = 5;
    launch(2'b01, 1'b1, 32'h1000_0000, 512, 32'h1100_0000, 10000);
    wait_strobe(50);
    @(posedge clk); #1;
    layer_start = 1'b1; mode = 2'b10; weight_addr = 32'h2200_0000; weight_bytes = 64;
    @(posedge clk); #1 layer_start = 1'b0;
    wait_layer_done(500);
    check("3x3 chunk_cnt", chunk_cnt, 3);
    @(negedge clk);
    check("3x3 busy after done", busy, 0);

    // 1x1 without bias
    launch(2'b10, 1'b0, 32'h3000_0000, 256, 32'h1200_0000, 4096);
    wait_layer_done(500);
    check("1x1 chunk_cnt", chunk_cnt, 2);

    // Zero sizes: busy for exactly the two cycles before layer_done drops
    launch(2'b01, 1'b1, 32'h1000_0000, 0, 32'h1100_0000, 0);
    @(negedge clk);
    check("zero busy c1", busy, 1);
    check("zero layer_done c1", layer_done, 0);
    @(negedge clk);
    check("zero busy c2", busy, 1);
    check("zero layer_done c2", layer_done, 1);
    @(negedge clk);
    check("zero busy c3", busy, 0);
    check("zero chunk_cnt", chunk_cnt, 0);

    // Backpressure before the second chunk
    launch(2'b01, 1'b0, 0, 0, 32'h4000_0000, 6000);
    wait_strobe(50);
    wbuf_main = 1'b0;
    a0 = dma_addr;
    stall_strobes = 0; addr_changes = 0;
    repeat (25) begin
      @(negedge clk);
      if (dma_start) stall_strobes++;
      if (dma_addr != a0) addr_changes++;
    end
    check("stall strobes", stall_strobes, 0);
    check("stall addr changes", addr_changes, 0);
    @(posedge clk); #1 wbuf_main = 1'b1;
    @(negedge clk);
    check("stall release same cycle", dma_start, 0);
    @(negedge clk);
    check("stall release next cycle", dma_start, 1);
    wait_layer_done(200);
    check("stall chunk_cnt", chunk_cnt, 2);

    // Abort in W_WAIT of chunk 2, with a spurious dma_done on the same cycle
    resp_en = 1'b0;
    launch(2'b01, 1'b0, 0, 0, 32'h5000_0000, 10000);
    wait_strobe(50);
    pulse_stray(1'b0);
    wait_strobe(50);
    pulse_stray(1'b1);
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort layer_done", layer_done, 0);
    check("abort dma_start", dma_start, 0);
    check("abort chunk_cnt", chunk_cnt, 1);
    exp_q.delete();
    exp_done = 0;
    repeat (10) @(negedge clk);
    check("abort chunk_cnt held", chunk_cnt, 1);
    resp_en = 1'b1;
    launch(2'b10, 1'b0, 0, 0, 32'h6000_0000, 4096);
    wait_layer_done(300);
    check("restart chunk_cnt", chunk_cnt, 2);

    // Ignored inputs: reserved mode and stray dma_done in IDLE
    launch(2'b11, 1'b1, 32'h7000_0000, 64, 32'h7100_0000, 64);
    pulse_stray(1'b0);
    busy_hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) busy_hits++;
    end
    check("ignored inputs busy", busy_hits, 0);
    check("ignored inputs chunk_cnt", chunk_cnt, 2);

    // Randomized layers with random DMA latency and weight-buffer backpressure
    rand_wbuf = 1'b1;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 7))
        0: m = 2'b00;
        1: m = 2'b11;
        2, 3, 4: m = 2'b01;
        default: m = 2'b10;
      endcase
      eb = 1'($urandom);
      ba = $urandom;
      bb = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 1024);
      wa = (i % 4 == 0) ? 32'hFFFF_E000 + $urandom_range(0, 255) : $urandom;
      wb = (i % 7 == 3) ? 0 : $urandom_range(1, 12000);
      resp_delay = $urandom_range(1, 4);
      launch(m, eb, ba, bb, wa, wb);
      if (m == 2'b01 || m == 2'b10) begin
        wait_layer_done(3000);
        check("random chunk_cnt", chunk_cnt, exp_chunks);
      end else begin
        @(negedge clk);
        check("random ignored busy", busy, 0);
      end
      repeat (2) @(posedge clk);
    end
    rand_wbuf = 1'b0;

    repeat (5) @(negedge clk);
    check("leftover commands", exp_q.size(), 0);
    check("leftover layer_done", exp_done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
